fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the team's synchronous FIFO (clk, wr_en, din, full) among N_REQ independent producers. It grants one producer at a time for a bounded burst, forwards that producer's data to the FIFO, stalls on FIFO full, and acknowledges each accepted word. It sits directly in front of the FIFO write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one synchronous FIFO write port
// among N_REQ producers. A granted producer keeps the port for up to
// MAX_BURST accepted words. The grant is then handed to the next requester
// in the same clock edge, so no idle cycle is inserted between bursts.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] din,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_din,
    output logic                    busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [3:0]      count_q, count_d;

    logic [DATA_W-1:0] words [N_REQ];
    logic              arb_found;
    logic [IW-1:0]     arb_idx;
    logic [IW-1:0]     cand;
    logic              wr;
    logic              burst_end;

    // Unpack the producer bus into one word per producer.
    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign words[i] = din[i*DATA_W +: DATA_W];
    end

    // Round-robin search starting just after the last owner. The last owner
    // is therefore examined last, so it can win only if nobody else asks.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(rr_q) + k) % N_REQ);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Write qualification. A burst ends on its last word or when the
    // owner withdraws its request. While the FIFO is full the owner keeps
    // the port and its count holds.
    always_comb begin
        wr        = (state_q == GRANT) && req[owner_q] && !fifo_full;
        burst_end = (state_q == GRANT) &&
                    (!req[owner_q] || (wr && (count_q == 4'(MAX_BURST - 1))));
    end

    // Next-state logic. Arbitration happens from IDLE and again at each
    // burst end.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d          = GRANT;
                    owner_d          = arb_idx;
                    rr_d             = arb_idx;
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    count_d          = '0;
                end
            end
            GRANT: begin
                if (burst_end) begin
                    count_d = '0;
                    if (arb_found) begin
                        owner_d          = arb_idx;
                        rr_d             = arb_idx;
                        grant_d          = '0;
                        grant_d[arb_idx] = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (wr) begin
                    count_d = count_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset. The pointer resets
    // to the last index, so the first search starts at producer 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= IW'(N_REQ - 1);
            grant_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    // Outputs are driven combinationally from the registered owner. Only
    // the owner can be acked, and only on an actual write.
    always_comb begin
        ack        = '0;
        fifo_wr_en = wr;
        fifo_din   = '0;
        if (state_q == GRANT) begin
            fifo_din     = words[owner_q];
            ack[owner_q] = wr;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter. Two instances share the stimulus, one with
// MAX_BURST=4 and one with MAX_BURST=1. A rule-level reference model tracks
// each instance: it records the owner, the words written so far and the
// last owner.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] din;
    logic            fifo_full;

    logic [N-1:0]  a_ack, a_grant, b_ack, b_grant;
    logic          a_wr, a_busy, b_wr, b_busy;
    logic [DW-1:0] a_din, b_din;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_W(DW), .N_REQ(N), .MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .req(req), .din(din), .ack(a_ack),
        .grant(a_grant), .fifo_full(fifo_full), .fifo_wr_en(a_wr),
        .fifo_din(a_din), .busy(a_busy)
    );

    fifo_wr_arbiter #(.DATA_W(DW), .N_REQ(N), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .req(req), .din(din), .ack(b_ack),
        .grant(b_grant), .fifo_full(fifo_full), .fifo_wr_en(b_wr),
        .fifo_din(b_din), .busy(b_busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model state per instance. An owner of -1 means idle.
    int m_owner [2];
    int m_cnt   [2];
    int m_ptr   [2];
    int m_mb    [2];

    logic [N-1:0] last_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic check_inst(input int i, input logic [N-1:0] g, input logic [N-1:0] a,
                              input logic w, input logic [DW-1:0] d, input logic b);
        logic [N-1:0]  eg, ea;
        logic          ew, eb;
        logic [DW-1:0] ed;
        string         pfx;
        pfx = (i == 0) ? "mb4" : "mb1";
        eg = '0; ea = '0; ew = 1'b0; eb = 1'b0; ed = '0;
        if (m_owner[i] >= 0) begin
            eg = N'(1 << m_owner[i]);
            ew = req[m_owner[i]] && !fifo_full;
            ea = ew ? eg : '0;
            ed = DW'(din >> (m_owner[i] * DW));
            eb = 1'b1;
        end
        chk({pfx, ".grant"}, 32'(g), 32'(eg));
        chk({pfx, ".ack"},   32'(a), 32'(ea));
        chk({pfx, ".wr_en"}, 32'(w), 32'(ew));
        chk({pfx, ".din"},   32'(d), 32'(ed));
        chk({pfx, ".busy"},  32'(b), 32'(eb));
    endtask

    // Apply the arbitration rules at a clock edge, using the inputs that
    // were presented during the cycle.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_owner[i] = -1;
                m_cnt[i]   = 0;
                m_ptr[i]   = N - 1;
            end else if (m_owner[i] < 0) begin
                if (req != 0) begin
                    m_owner[i] = pick(req, m_ptr[i]);
                    m_ptr[i]   = m_owner[i];
                    m_cnt[i]   = 0;
                end
            end else begin
                logic w;
                w = req[m_owner[i]] && !fifo_full;
                if (w) m_cnt[i]++;
                if (!req[m_owner[i]] || (w && m_cnt[i] == m_mb[i])) begin
                    m_cnt[i] = 0;
                    if (req != 0) begin
                        m_owner[i] = pick(req, m_owner[i]);
                        m_ptr[i]   = m_owner[i];
                    end else begin
                        m_owner[i] = -1;
                    end
                end
            end
        end
    endtask

    // Inputs are already driven, just after a negedge.
    task automatic cycle();
        #1;
        check_inst(0, a_grant, a_ack, a_wr, a_din, a_busy);
        check_inst(1, b_grant, b_ack, b_wr, b_din, b_busy);
        last_ack = a_ack;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) cycle();
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_g;
        m_mb[0] = 4;
        m_mb[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1; m_cnt[i] = 0; m_ptr[i] = N - 1;
        end
        rst = 1'b0; req = '0; din = '0; fifo_full = 1'b0; last_ack = '0;
        @(posedge clk);
        model_step();
        @(negedge clk);

        // Reset state, with a request pending that must be ignored.
        req = 4'b1111;
        do_reset(2);
        chk("rst.grant", 32'(a_grant), 32'h0);
        chk("rst.busy",  32'(a_busy),  32'h0);

        // Two steady requesters, with fixed burst timing for MAX_BURST=4.
        req = 4'b0101;
        din = 32'hA4B3C2D1;
        for (int c = 0; c < 12; c++) begin
            exp_g = (c == 0) ? 4'b0000 : (c <= 4) ? 4'b0001 :
                    (c <= 8) ? 4'b0100 : 4'b0001;
            #1;
            chk("seq.grant", 32'(a_grant), 32'(exp_g));
            #0;
            cycle();
        end

        // A single requester hands over to itself without a bubble.
        do_reset(1);
        req = 4'b1000;
        repeat (12) cycle();

        // The owner stalls on full, then the bus rotates with MAX_BURST=1.
        do_reset(1);
        req = 4'b1111;
        din = 32'h44332211;
        repeat (3) cycle();
        fifo_full = 1'b1;
        repeat (4) cycle();
        fifo_full = 1'b0;
        repeat (8) cycle();

        // Randomized producers that hold each word until acked by dut_a.
        do_reset(1);
        req = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_ack[i] || !req[i]) begin
                    req[i] = ($urandom_range(0, 99) < 60);
                    din[i*DW +: DW] = DW'($urandom);
                end else if ($urandom_range(0, 99) < 4) begin
                    req[i] = 1'b0;
                end
            end
            fifo_full = ($urandom_range(0, 99) < 25);
            rst       = ($urandom_range(0, 199) != 0);
            last_ack  = '0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
